// File: rtl/lpc_sniffer_pkg.sv
// lpc_sniffer_pkg: constants shared by the LPC sniffer output path.
//   - ASCII codes used when rendering records as hex text.
//   - Field offsets/widths of the 48-bit ring-buffer record.
//   - Line length, which depends on the terminator build option.
// Build option: MEM2HEX_CRLF_EN defined -> CR LF terminator (15-byte line),
//               undefined -> LF-only terminator (14-byte line).
package lpc_sniffer_pkg;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_A     = 8'h41;

    // Record layout: [47:16] addr, [15:8] data, [7:4] reserved, [3:0] cyctype_dir
    localparam int REC_W    = 48;
    localparam int ADDR_LSB = 16;
    localparam int ADDR_W   = 32;
    localparam int DATA_LSB = 8;
    localparam int DATA_W   = 8;
    localparam int CYC_LSB  = 0;
    localparam int CYC_W    = 4;

`ifdef MEM2HEX_CRLF_EN
    localparam int LINE_LEN = 15;
`else
    localparam int LINE_LEN = 14;
`endif
    localparam logic [3:0] LAST_IDX = 4'(LINE_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LATCH,
        SEND,
        GUARD
    } m2h_state_e;

endpackage

// File: rtl/hex_nibble.sv
// hex_nibble: combinational 4-bit value to uppercase ASCII hex digit.
// Ports:
//   nib_i    in  4  nibble value
//   ascii_o  out 8  '0'..'9' or 'A'..'F'
module hex_nibble
    import lpc_sniffer_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [7:0] ascii_o
);

    always_comb begin
        if (nib_i < 4'd10) begin
            ascii_o = ASCII_0 + {4'h0, nib_i};
        end else begin
            ascii_o = ASCII_A + {4'h0, nib_i} - 8'd10;
        end
    end

endmodule

// File: rtl/mem2hex.sv
// mem2hex: drains 48-bit LPC cycle records from the ring buffer and emits
// each one as an ASCII line "C AAAAAAAA DD" + terminator to uart_tx.
// Build option: MEM2HEX_CRLF_EN selects a CR LF terminator (else LF only).
// Ports:
//   clock              in   1   system clock (ext_clock domain)
//   reset              in   1   synchronous, active-high
//   read_empty         in   1   ring buffer empty flag
//   read_clock_enable  out  1   single-cycle read strobe
//   read_data          in  48   record, valid the cycle after the strobe
//   uart_ready         in   1   uart_tx able to accept a byte
//   uart_clock_enable  out  1   single-cycle byte strobe
//   uart_data          out  8   byte, registered, valid while strobe is high
module mem2hex
    import lpc_sniffer_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        read_empty,
    output logic        read_clock_enable,
    input  logic [47:0] read_data,
    input  logic        uart_ready,
    output logic        uart_clock_enable,
    output logic [7:0]  uart_data
);

    m2h_state_e  state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [REC_W-1:0] rec_q, rec_d;
    logic [7:0]  data_q, data_d;

    logic [ADDR_W-1:0] addr_sh;
    logic [3:0]  nib;
    logic [7:0]  nib_ascii;
    logic [7:0]  byte_sel;

    // Reserved record bits are stored with the record but never rendered.
    logic rsvd_unused;
    assign rsvd_unused = ^rec_q[7:4];

    // Strobes are Mealy outputs of the current state so a byte issues in the
    // same cycle SEND sees uart_ready. They are masked during reset so the
    // ring buffer is never popped into a record that reset would discard.
    always_comb begin
        state_d           = state_q;
        idx_d             = idx_q;
        rec_d             = rec_q;
        read_clock_enable = 1'b0;
        uart_clock_enable = 1'b0;
        case (state_q)
            IDLE: begin
                if (!read_empty) begin
                    read_clock_enable = 1'b1;
                    state_d           = FETCH;
                end
            end
            FETCH: state_d = LATCH;
            LATCH: begin
                rec_d   = read_data;
                idx_d   = 4'd0;
                state_d = SEND;
            end
            SEND: begin
                if (uart_ready) begin
                    uart_clock_enable = 1'b1;
                    state_d           = GUARD;
                end
            end
            GUARD: begin
                // uart_ready is not looked at here: uart_tx may still show
                // ready for one cycle after accepting the previous byte.
                if (idx_q == LAST_IDX) begin
                    state_d = IDLE;
                end else begin
                    idx_d   = idx_q + 4'd1;
                    state_d = SEND;
                end
            end
            default: state_d = IDLE;
        endcase
        if (reset) begin
            read_clock_enable = 1'b0;
            uart_clock_enable = 1'b0;
        end
    end

    // Byte for the index about to be presented. Computed from the next-state
    // record/index so uart_data is already registered when SEND is entered.
    // Address nibbles (indices 2..9) come MSB first by shifting left.
    assign addr_sh = rec_d[ADDR_LSB +: ADDR_W] << {idx_d - 4'd2, 2'b00};

    always_comb begin
        case (idx_d)
            4'd0:    nib = rec_d[CYC_LSB +: CYC_W];
            4'd11:   nib = rec_d[DATA_LSB + 4 +: 4];
            4'd12:   nib = rec_d[DATA_LSB +: 4];
            default: nib = addr_sh[ADDR_W-1 -: 4];
        endcase
    end

    hex_nibble u_hex (
        .nib_i   (nib),
        .ascii_o (nib_ascii)
    );

    always_comb begin
        byte_sel = ASCII_SPACE;
        case (idx_d)
            4'd1, 4'd10: byte_sel = ASCII_SPACE;
`ifdef MEM2HEX_CRLF_EN
            4'd13:       byte_sel = ASCII_CR;
            4'd14:       byte_sel = ASCII_LF;
`else
            4'd13:       byte_sel = ASCII_LF;
`endif
            default:     byte_sel = nib_ascii;
        endcase
        data_d = data_q;
        if (state_d == SEND && state_q != SEND) begin
            data_d = byte_sel;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= 4'd0;
            rec_q   <= '0;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rec_q   <= rec_d;
            data_q  <= data_d;
        end
    end

    assign uart_data = data_q;

endmodule

// File: tb/tb_mem2hex.sv
// tb_mem2hex: self-checking bench for mem2hex. A queue models the ring
// buffer, a small process models uart_tx ready behaviour, and received bytes
// are compared against either literal line text or a hex-rendering model.
module tb_mem2hex;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        read_empty = 1'b1;
    logic        uart_ready = 1'b0;
    logic [47:0] read_data = '0;
    logic        read_clock_enable;
    logic        uart_clock_enable;
    logic [7:0]  uart_data;

    always #5 clock = ~clock;

    mem2hex dut (
        .clock             (clock),
        .reset             (reset),
        .read_empty        (read_empty),
        .read_clock_enable (read_clock_enable),
        .read_data         (read_data),
        .uart_ready        (uart_ready),
        .uart_clock_enable (uart_clock_enable),
        .uart_data         (uart_data)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [47:0] rb[$];
    logic [7:0]  rx[$];
    logic [7:0]  exp_q[$];
    int          rx_cyc[$];
    int          cyc = 0;
    int          n_rce = 0;
    int          gap = 0;
    int          gap_cnt = 0;
    bit          rce_seen = 1'b0;
    bit          uce_seen = 1'b0;
    int          last_uce = -10;
    int          last_rce = -10;

    function automatic void check(string name, logic [63:0] got, logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endfunction

    // Monitor: sample outputs on the falling edge.
    always @(negedge clock) begin
        cyc++;
        rce_seen = read_clock_enable;
        uce_seen = uart_clock_enable;
        if (read_clock_enable) begin
            check("rce_while_empty", {63'd0, read_empty}, 64'd0);
            check("rce_back_to_back", {63'd0, (cyc - last_rce) >= 2}, 64'd1);
            last_rce = cyc;
        end
        if (uart_clock_enable) begin
            check("uce_without_ready", {63'd0, uart_ready}, 64'd1);
            check("uce_spacing", {63'd0, (cyc - last_uce) >= 2}, 64'd1);
            last_uce = cyc;
            rx.push_back(uart_data);
            rx_cyc.push_back(cyc);
        end
    end

    // Ring buffer and uart_tx models, updated just after each rising edge.
    always @(posedge clock) begin
        #1;
        if (rce_seen && rb.size() > 0) begin
            read_data = rb.pop_front();
            n_rce++;
        end
        read_empty = (rb.size() == 0);
        if (uce_seen) gap_cnt = gap;
        if (gap_cnt > 0) begin
            uart_ready = 1'b0;
            gap_cnt--;
        end else begin
            uart_ready = 1'b1;
        end
    end

    function automatic logic [7:0] hexch(logic [3:0] n);
        int v;
        v = int'(n);
        return (v < 10) ? 8'(48 + v) : 8'(65 + v - 10);
    endfunction

    function automatic void push_term();
`ifdef MEM2HEX_CRLF_EN
        exp_q.push_back(8'h0D);
`endif
        exp_q.push_back(8'h0A);
    endfunction

    function automatic void push_str(string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
        push_term();
    endfunction

    // Reference rendering: "C AAAAAAAA DD" + terminator.
    function automatic void push_rec(logic [47:0] r);
        exp_q.push_back(hexch(r[3:0]));
        exp_q.push_back(8'h20);
        for (int k = 7; k >= 0; k--) exp_q.push_back(hexch(r[16 + 4*k +: 4]));
        exp_q.push_back(8'h20);
        exp_q.push_back(hexch(r[15:12]));
        exp_q.push_back(hexch(r[11:8]));
        push_term();
    endfunction

    task automatic tick(int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    task automatic start_test(int g);
        rx.delete();
        rx_cyc.delete();
        exp_q.delete();
        n_rce = 0;
        gap = g;
    endtask

    task automatic load(logic [47:0] r);
        rb.push_back(r);
        read_empty = 1'b0;
    endtask

    task automatic wait_bytes(int n, int budget);
        int k;
        k = 0;
        while (rx.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        if (k >= budget) check("timeout_waiting_bytes", 64'(rx.size()), 64'(n));
        tick(12);
        check("byte_count", 64'(rx.size()), 64'(n));
    endtask

    task automatic compare_bytes(string name);
        for (int i = 0; i < exp_q.size() && i < rx.size(); i++)
            check($sformatf("%s_byte%0d", name, i), {56'd0, rx[i]}, {56'd0, exp_q[i]});
    endtask

    typedef struct {
        logic [47:0] rec;
        int          g;
        string       txt;
    } vec_t;

    vec_t tbl[5];
    int   k;
    int   nrec;
    logic [47:0] r;

    initial begin
        tbl[0] = '{ {32'h00000080, 8'h5A, 4'h0, 4'h2}, 0, "2 00000080 5A" };
        tbl[1] = '{ {32'hDEADBEEF, 8'hFF, 4'hA, 4'hF}, 0, "F DEADBEEF FF" };
        tbl[2] = '{ {32'h00000080, 8'h5A, 4'h0, 4'h2}, 5, "2 00000080 5A" };
        tbl[3] = '{ {32'h12345678, 8'h9C, 4'h0, 4'hB}, 1, "B 12345678 9C" };
        tbl[4] = '{ {32'hA0B1C2D3, 8'h00, 4'h5, 4'h0}, 2, "0 A0B1C2D3 00" };

        // Reset state
        tick(3);
        reset = 1'b0;
        tick(1);
        check("reset_rce", {63'd0, read_clock_enable}, 64'd0);
        check("reset_uce", {63'd0, uart_clock_enable}, 64'd0);
        check("reset_uart_data", {56'd0, uart_data}, 64'd0);

        // Table-driven single lines
        for (int i = 0; i < 5; i++) begin
            start_test(tbl[i].g);
            push_str(tbl[i].txt);
            load(tbl[i].rec);
            wait_bytes(exp_q.size(), 600);
            compare_bytes($sformatf("tbl%0d", i));
            check($sformatf("tbl%0d_reads", i), 64'(n_rce), 64'd1);
        end

        // Two records queued back to back
        start_test(0);
        push_str("3 0000FFFF 12");
        push_str("C 80000001 E7");
        load({32'h0000FFFF, 8'h12, 4'h0, 4'h3});
        load({32'h80000001, 8'hE7, 4'h0, 4'hC});
        wait_bytes(exp_q.size(), 600);
        compare_bytes("pair");
        check("pair_reads", 64'(n_rce), 64'd2);
        if (rx_cyc.size() > exp_q.size() / 2) begin
            k = exp_q.size() / 2;
            check("pair_line_gap", {63'd0, (rx_cyc[k] - rx_cyc[k-1]) >= 5}, 64'd1);
        end

        // Reset in the middle of a line
        start_test(0);
        load({32'h11223344, 8'h55, 4'h0, 4'h6});
        begin
            int b;
            b = 0;
            while (rx.size() < 6 && b < 200) begin tick(1); b++; end
            check("mid_reset_reached_byte6", 64'(rx.size()), 64'd6);
        end
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("mid_reset_uce", {63'd0, uart_clock_enable}, 64'd0);
        check("mid_reset_rce", {63'd0, read_clock_enable}, 64'd0);
        check("mid_reset_uart_data", {56'd0, uart_data}, 64'd0);
        tick(20);
        check("mid_reset_no_more_bytes", 64'(rx.size()), 64'd6);
        rx.delete();
        rx_cyc.delete();
        push_str("9 CAFEF00D 42");
        load({32'hCAFEF00D, 8'h42, 4'h0, 4'h9});
        wait_bytes(exp_q.size(), 600);
        compare_bytes("after_reset");
        check("after_reset_reads", 64'(n_rce), 64'd2);

        // Randomized records against the rendering model
        for (int t = 0; t < 8; t++) begin
            start_test(int'($urandom_range(0, 3)));
            nrec = int'($urandom_range(1, 3));
            for (int j = 0; j < nrec; j++) begin
                r = {$urandom(), 16'($urandom())};
                push_rec(r);
                load(r);
            end
            wait_bytes(exp_q.size(), 2000);
            compare_bytes($sformatf("rand%0d", t));
            check($sformatf("rand%0d_reads", t), 64'(n_rce), 64'(nrec));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
